// File: rtl/aes_pkg.sv
// Shared AES state types and FIPS-197 byte addressing helpers.
// Byte k of a state lives at bits [127-8k -: 8]; s[r][c] is byte 4c+r.
package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int NB      = 4;
  localparam int NROW    = 4;
  localparam int STATE_W = BYTE_W * NB * NROW;

  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [STATE_W-1:0] state_t;

  function automatic int byte_idx(input int r, input int c);
    return NB * c + r;
  endfunction

  // Column that feeds s'[r][c]: rotate row r left (forward) or right (inverse) by r.
  function automatic int src_col(input int r, input int c, input bit inverse);
    if (inverse) begin
      return (c + NB - r) % NB;
    end
    return (c + r) % NB;
  endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Fixed ShiftRows / InvShiftRows byte permutation, pure wiring.
// Zero latency; no flow control.
module shift_rows_perm
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b0
) (
  input  logic [STATE_W-1:0] i_data,
  output logic [STATE_W-1:0] o_data
);

  for (genvar r = 0; r < NROW; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int DST = byte_idx(r, c);
      localparam int SRC = byte_idx(r, src_col(r, c, INVERSE));
      assign o_data[STATE_W-1-BYTE_W*DST -: BYTE_W] = i_data[STATE_W-1-BYTE_W*SRC -: BYTE_W];
    end
  end

endmodule

// File: rtl/shift_rows.sv
// Independent forward and inverse ShiftRows with optional output register.
// Latency 1 cycle (OUT_REG=1) or 0; accepts one state per cycle, never stalls.
module shift_rows
  import aes_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [STATE_W-1:0] in_fwd,
  input  logic [STATE_W-1:0] in_inv,
  output logic               out_valid,
  output logic [STATE_W-1:0] out_fwd,
  output logic [STATE_W-1:0] out_inv
);

  logic [STATE_W-1:0] w_fwd;
  logic [STATE_W-1:0] w_inv;

  shift_rows_perm #(.INVERSE(1'b0)) u_perm_fwd (
    .i_data (in_fwd),
    .o_data (w_fwd)
  );

  shift_rows_perm #(.INVERSE(1'b1)) u_perm_inv (
    .i_data (in_inv),
    .o_data (w_inv)
  );

  if (OUT_REG) begin : g_reg
    logic   r_valid;
    state_t r_fwd;
    state_t r_inv;

    // Data only moves on a valid beat so idle cycles keep the last result visible.
    always_ff @(posedge clock) begin
      if (reset) begin
        r_valid <= 1'b0;
        r_fwd   <= '0;
        r_inv   <= '0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_fwd <= w_fwd;
          r_inv <= w_inv;
        end
      end
    end

    assign out_valid = r_valid;
    assign out_fwd   = r_fwd;
    assign out_inv   = r_inv;
  end else begin : g_comb
    assign out_valid = in_valid;
    assign out_fwd   = w_fwd;
    assign out_inv   = w_inv;
  end

endmodule

// File: tb/tb_shift_rows.sv
// Directed vectors, streamed round trip and reset/gap sequences for shift_rows.
module tb_shift_rows;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic [127:0] in_fwd;
  logic [127:0] in_inv;
  logic         out_valid;
  logic [127:0] out_fwd;
  logic [127:0] out_inv;

  int n_checks = 0;
  int n_fail   = 0;

  shift_rows #(.OUT_REG(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_fwd    (in_fwd),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_fwd   (out_fwd),
    .out_inv   (out_inv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] fwd_in;
    logic [127:0] inv_in;
    logic [127:0] fwd_exp;
    logic [127:0] inv_exp;
  } vec_t;

  localparam logic [127:0] SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQF = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] SEQI = 128'h000d0a0704010e0b0805020f0c090603;
  localparam logic [127:0] SEQ2 = 128'h0009020b040d060f08010a030c050e07;
  localparam logic [127:0] FIPS = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPF = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  // Reference: s'[r][c] = s[r][(c +/- r) mod 4], bytes addressed in string order.
  function automatic logic [127:0] model(input logic [127:0] x, input bit inv);
    logic [127:0] y;
    y = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int sc;
        sc = inv ? (c - r + 4) % 4 : (c + r) % 4;
        y[127 - 8*(4*c + r) -: 8] = x[127 - 8*(4*sc + r) -: 8];
      end
    end
    return y;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  vec_t         vecs[6];
  logic [127:0] xs[1000];
  logic [127:0] fb;

  initial begin
    vecs[0] = '{SEQ,   SEQ,   SEQF,  SEQI};
    vecs[1] = '{FIPS,  FIPF,  FIPF,  FIPS};
    vecs[2] = '{128'h0, 128'h0, 128'h0, 128'h0};
    vecs[3] = '{{128{1'b1}}, {128{1'b1}}, {128{1'b1}}, {128{1'b1}}};
    vecs[4] = '{SEQF,  SEQI,  SEQ2,  SEQ2};
    vecs[5] = '{SEQ,   FIPF,  SEQF,  FIPS};

    reset    = 1'b1;
    in_valid = 1'b1;
    in_fwd   = SEQ;
    in_inv   = SEQ;
    repeat (2) @(negedge clock);
    chk1("reset_valid", out_valid, 1'b0);
    chk("reset_fwd", out_fwd, 128'h0);
    chk("reset_inv", out_inv, 128'h0);

    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);

    // Directed table, one vector per cycle followed by an idle cycle.
    for (int i = 0; i < 6; i++) begin
      in_fwd   = vecs[i].fwd_in;
      in_inv   = vecs[i].inv_in;
      in_valid = 1'b1;
      @(negedge clock);
      chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_fwd", i), out_fwd, vecs[i].fwd_exp);
      chk($sformatf("vec%0d_inv", i), out_inv, vecs[i].inv_exp);
      in_valid = 1'b0;
      @(negedge clock);
      chk1($sformatf("vec%0d_idle", i), out_valid, 1'b0);
    end

    // Streamed round trip: forward output is fed back into the inverse path.
    for (int i = 0; i < 1000; i++) xs[i] = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    for (int k = 0; k < 1002; k++) begin
      if (k >= 1) begin
        chk1("rt_valid", out_valid, 1'b1);
        chk("rt_fwd", out_fwd, model(xs[k-1], 1'b0));
      end
      if (k >= 2) chk("rt_inv", out_inv, xs[k-2]);
      fb     = out_fwd;
      in_fwd = (k < 1000) ? xs[k] : 128'h0;
      in_inv = fb;
      @(negedge clock);
    end

    // Reset mid-stream discards the pending beat.
    in_fwd = FIPS;
    in_inv = FIPF;
    reset  = 1'b1;
    @(negedge clock);
    chk1("mid_reset_valid", out_valid, 1'b0);
    chk("mid_reset_fwd", out_fwd, 128'h0);
    chk("mid_reset_inv", out_inv, 128'h0);

    reset  = 1'b0;
    in_fwd = SEQ;
    in_inv = SEQ;
    @(negedge clock);
    chk1("post_reset_valid", out_valid, 1'b1);
    chk("post_reset_fwd", out_fwd, SEQF);
    chk("post_reset_inv", out_inv, SEQI);

    // Idle gap with changing inputs: data must hold.
    in_valid = 1'b0;
    in_fwd   = FIPS;
    in_inv   = FIPF;
    repeat (2) begin
      @(negedge clock);
      chk1("gap_valid", out_valid, 1'b0);
      chk("gap_fwd", out_fwd, SEQF);
      chk("gap_inv", out_inv, SEQI);
    end

    in_valid = 1'b1;
    @(negedge clock);
    chk1("resume_valid", out_valid, 1'b1);
    chk("resume_fwd", out_fwd, FIPF);
    chk("resume_inv", out_inv, FIPS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_rows.md
SHIFT_ROWS -- requirements
Module: shift_rows

Interface
REQ-001 Parameter OUT_REG, default 1, 1 = outputs registered (1-cycle latency); 0 = combinational outputs, valid passes straight through.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_fwd/in_inv qualified this cycle.
REQ-005 in_fwd  input  128  AES state for forward ShiftRows.
REQ-006 in_inv  input  128  AES state for inverse ShiftRows.
REQ-007 out_valid  output  1  out_fwd/out_inv hold results for a valid input.
REQ-008 out_fwd  output  128  ShiftRows(in_fwd).
REQ-009 out_inv  output  128  InvShiftRows(in_inv).

Function
REQ-010 State byte order: FIPS-197 string order; byte k = bits [127-8k -: 8], k=0..15; state s[r][c] = byte 4c+r (column-major).
REQ-011 Forward: out[r][c] = in[r][(c+r) mod 4] for r,c in 0..3; row 0 unchanged, row r rotated left by r bytes.
REQ-012 Inverse: out[r][c] = in[r][(c-r) mod 4]; row r rotated right by r bytes.
REQ-013 Both paths are pure byte permutations: no arithmetic, no data-dependent behaviour, every input byte appears exactly once in the output.
REQ-014 Forward and inverse paths are independent; both are computed every cycle.
REQ-015 OUT_REG=1: on a clock edge with in_valid=1 and reset=0, out_fwd/out_inv load the permuted data and out_valid=1; result visible the cycle after input.
REQ-016 OUT_REG=1: on a clock edge with in_valid=0, data outputs hold their previous values and out_valid=0.
REQ-017 Back-to-back in_valid each cycle sustains throughput of one result per cycle with no bubbles and no backpressure.
REQ-018 OUT_REG=0: out_fwd/out_inv are combinational functions of the inputs and out_valid=in_valid; clock and reset have no effect.

Reset
REQ-019 OUT_REG=1: reset=1 at a clock edge forces out_valid=0, out_fwd=0 and out_inv=0, overriding in_valid.
REQ-020 Reset asserted mid-stream discards any pending result. The first valid input after reset deasserts produces a result one cycle later.

Structure
REQ-021 Shared package (aes_pkg) holds the 128-bit state typedef, the byte typedef, and the byte-index helper mapping (r,c) to 4c+r.
REQ-022 One combinational sub-module, shift_rows_perm (parameter INVERSE 0/1, 128-bit in/out), is instantiated twice: forward and inverse. shift_rows adds only the valid/output registers.

Verification
REQ-023 in_fwd=000102030405060708090a0b0c0d0e0f, in_valid=1 -> next cycle out_fwd=00050a0f04090e03080d02070c01060b, out_valid=1.
REQ-024 in_inv=000102030405060708090a0b0c0d0e0f -> out_inv=000d0a0704010e0b0805020f0c090603.
REQ-025 FIPS-197 App. B round 1: in_fwd=d42711aee0bf98f1b8b45de51e415230 -> out_fwd=d4bf5d30e0b452aeb84111f11e2798e5. The same value applied on in_inv recovers the original.
REQ-026 Round trip: 1000 random states x; feed x to forward, feed that result to inverse -> inverse output equals x for every x; streamed back-to-back with in_valid held at 1.
REQ-027 Reset: stream valid data, assert reset for 1 cycle mid-stream -> next cycle out_valid=0 and out_fwd=out_inv=0. Gaps with in_valid=0 -> out_valid=0 and data held.
